vc_rr_sel: RTL and testbench
============================

VC_RR_SEL -- requirements
Module: vc_rr_sel

Interface
REQ-001 SHALL have parameter NUM_VC, default 5: number of virtual channels per input port.
REQ-002 SHALL have parameter VC_INDEX_WIDTH, default 3: width of the VC index.
REQ-003 SHALL have parameter AGE_LIMIT, default 15: hold-timeout threshold in cycles; used only under REQ-030.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vc_req  input  NUM_VC  bit i high when VC i holds a head flit with a valid route request.
REQ-007 SHALL have port sw_grant  input  1  switch allocator granted this input port this cycle.
REQ-008 SHALL have port flit_tail  input  1  flit leaving under the current grant is a tail (single-flit packets assert it).
REQ-009 SHALL have port sel  output  VC_INDEX_WIDTH  registered index of the selected VC; drives the 5:1 per-port request mux select.
REQ-010 SHALL have port sel_valid  output  1  registered; sel is meaningful.
REQ-011 SHALL have port vc_deq  output  NUM_VC  one-hot dequeue strobe to the VC buffers.

Function
REQ-012 SHALL implement two states, SEARCH and HOLD, plus a round-robin pointer ptr of VC_INDEX_WIDTH bits.
REQ-013 In SEARCH with vc_req nonzero, the block SHALL load sel with the first requesting VC at or after ptr, cyclically; set sel_valid; and enter HOLD at the next edge.
REQ-014 Latency SHALL be exactly one cycle: vc_req seen at edge N gives sel_valid=1 after edge N.
REQ-015 In SEARCH with vc_req==0, state, sel and ptr SHALL hold and sel_valid SHALL be 0.
REQ-016 In HOLD, sel SHALL stay stable until release, regardless of vc_req changes (wormhole lock).
REQ-017 vc_deq SHALL equal the one-hot decode of sel ANDed with (sw_grant & sel_valid), combinationally, in the same cycle.
REQ-018 If sw_grant is high while sel_valid=0, it SHALL be ignored: vc_deq=0 and no state change.
REQ-019 sw_grant & flit_tail in HOLD SHALL release the lock: ptr=sel+1 with wrap NUM_VC-1 to 0, sel_valid=0, next state SEARCH.
REQ-020 sw_grant without flit_tail in HOLD SHALL keep HOLD with sel unchanged.
REQ-021 After a release there SHALL be exactly one bubble cycle (sel_valid=0) before the next selection.
REQ-022 flit_tail without sw_grant SHALL be ignored.
REQ-023 sel SHALL never exceed NUM_VC-1; pointer arithmetic SHALL be modulo NUM_VC, not 2^VC_INDEX_WIDTH.

Reset
REQ-024 reset sampled high SHALL force SEARCH, ptr=0, sel=0, sel_valid=0 at that edge.
REQ-025 While reset is high, vc_deq SHALL be 0.
REQ-026 Reset asserted mid-packet in HOLD SHALL abandon the lock without any vc_deq.
REQ-027 reset SHALL take priority over sw_grant, flit_tail and vc_req in the same cycle.

Configuration
REQ-028 Macro VC_SEL_AGE_LIMIT_EN SHALL gate a hold-timeout feature.
REQ-029 Without VC_SEL_AGE_LIMIT_EN, HOLD SHALL persist until a tail grant (REQ-019); no age counter SHALL exist.
REQ-030 With VC_SEL_AGE_LIMIT_EN, a 4-bit age counter SHALL behave as follows:
- Clears on entry to HOLD.
- Increments each HOLD cycle without sw_grant, saturating at 15.
- Is frozen once any grant has occurred for the current packet.
- When it equals AGE_LIMIT with no grant yet: release (ptr=sel+1, sel_valid=0, SEARCH) and pulse no vc_deq.
REQ-031 With VC_SEL_AGE_LIMIT_EN, the counter SHALL reset to 0 under reset.

Verification
REQ-032 Cover: reset, then vc_req=5'b00100 -> sel=2, sel_valid=1 one cycle later; sw_grant+flit_tail -> vc_deq=5'b00100, then sel_valid=0, ptr=3.
REQ-033 Cover: ptr=3, vc_req=5'b00011 -> sel=0 (wrap); tail grant -> ptr=1.
REQ-034 Cover: 3-flit packet on VC4 with grants on cycles 1,2,3, tail on 3, vc_req changes mid-packet -> sel stays 4 throughout; vc_deq=5'b10000 on each grant; ptr=0 after release.
REQ-035 Cover: sw_grant=1 while sel_valid=0 -> vc_deq=0, state unchanged.
REQ-036 Cover: reset asserted in HOLD with sw_grant high -> vc_deq=0; sel=0, sel_valid=0 after the edge.
REQ-037 Cover (VC_SEL_AGE_LIMIT_EN): HOLD on VC1 with no grant for 15 cycles -> release, ptr=2; without the macro -> sel=1 held indefinitely.

Source files
------------

// File: rtl/vc_rr_sel.sv
// vc_rr_sel: round-robin VC selector with a wormhole hold lock for one input port.
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - synchronous active-high reset
//   vc_req     - per-VC head-flit route request
//   sw_grant   - switch allocator granted this port this cycle
//   flit_tail  - flit leaving under the current grant is a tail
//   sel        - registered index of the selected VC
//   sel_valid  - registered, sel is meaningful (high while the lock is held)
//   vc_deq     - one-hot dequeue strobe, combinational from sel and sw_grant
// Macro VC_SEL_AGE_LIMIT_EN adds a hold timeout that releases a lock whose
// packet has not received any grant within AGE_LIMIT cycles.
module vc_rr_sel #(
    parameter int NUM_VC         = 5,
    parameter int VC_INDEX_WIDTH = 3,
    parameter int AGE_LIMIT      = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_VC-1:0]         vc_req,
    input  logic                      sw_grant,
    input  logic                      flit_tail,
    output logic [VC_INDEX_WIDTH-1:0] sel,
    output logic                      sel_valid,
    output logic [NUM_VC-1:0]         vc_deq
);
    typedef enum logic {SEARCH, HOLD} state_e;
    state_e                    state_q, state_d;
    logic [VC_INDEX_WIDTH-1:0] ptr_q, ptr_d, sel_q, sel_d, pick, sel_inc;
    logic                      timeout;
    // Scan downward so the lowest cyclic offset from ptr wins.
    always_comb begin
        pick = ptr_q;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            logic [VC_INDEX_WIDTH:0] idx;
            idx = {1'b0, ptr_q} + (VC_INDEX_WIDTH+1)'(k);
            if (idx >= (VC_INDEX_WIDTH+1)'(NUM_VC)) idx = idx - (VC_INDEX_WIDTH+1)'(NUM_VC);
            if (vc_req[idx[VC_INDEX_WIDTH-1:0]]) pick = idx[VC_INDEX_WIDTH-1:0];
        end
    end
    // Wrap at NUM_VC, not at the power of two of the index width.
    assign sel_inc = (sel_q == VC_INDEX_WIDTH'(NUM_VC - 1)) ? '0 : sel_q + 1'b1;
`ifdef VC_SEL_AGE_LIMIT_EN
    logic [3:0] age_q, age_d;
    logic       granted_q, granted_d;
    assign timeout = (state_q == HOLD) && !granted_q && (age_q == 4'(AGE_LIMIT));
    // Counter is cleared while searching, so it starts at zero on HOLD entry.
    always_comb begin
        age_d     = age_q;
        granted_d = granted_q;
        if (state_q == SEARCH) begin
            age_d     = '0;
            granted_d = 1'b0;
        end else if (sw_grant) begin
            granted_d = 1'b1;
        end else if (!granted_q && age_q != 4'hf) begin
            age_d = age_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            age_q     <= '0;
            granted_q <= 1'b0;
        end else begin
            age_q     <= age_d;
            granted_q <= granted_d;
        end
    end
`else
    logic unused_age;
    assign unused_age = (AGE_LIMIT != 0);
    assign timeout    = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        if (state_q == SEARCH) begin
            if (|vc_req) begin
                sel_d   = pick;
                state_d = HOLD;
            end
        end else if (timeout || (sw_grant && flit_tail)) begin
            ptr_d   = sel_inc;
            state_d = SEARCH;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end
    assign sel       = sel_q;
    assign sel_valid = (state_q == HOLD);
    // A timing-out packet and a port under reset must never dequeue.
    assign vc_deq    = (sw_grant && sel_valid && !reset && !timeout) ? (NUM_VC'(1) << sel_q) : '0;
endmodule

// File: tb/tb_vc_rr_sel.sv
// tb_vc_rr_sel: directed and pseudo-random bench for vc_rr_sel with a behavioural model.
module tb_vc_rr_sel;
    localparam int NUM_VC = 5;
    localparam int AGE    = 15;
`ifdef VC_SEL_AGE_LIMIT_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_VC-1:0] vc_req = '0;
    logic              sw_grant = 1'b0;
    logic              flit_tail = 1'b0;
    logic [2:0]        sel;
    logic              sel_valid;
    logic [NUM_VC-1:0] vc_deq;
    int errors = 0;
    int checks = 0;
    bit m_init = 1'b0;
    bit m_hold, m_g;
    int m_sel, m_ptr, m_age;

    vc_rr_sel dut (
        .clk(clk), .reset(reset), .vc_req(vc_req), .sw_grant(sw_grant),
        .flit_tail(flit_tail), .sel(sel), .sel_valid(sel_valid), .vc_deq(vc_deq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic bit tmo();
        return AGE_EN && m_hold && !m_g && m_age == AGE;
    endfunction

    // Model: a locked VC index plus a cyclic search start.
    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1; m_hold = 1'b0; m_sel = 0; m_ptr = 0; m_age = 0; m_g = 1'b0;
        end else if (m_init) begin
            if (!m_hold) begin
                if (vc_req != 0) begin
                    for (int k = 0; k < NUM_VC; k++)
                        if (vc_req[(m_ptr + k) % NUM_VC]) begin
                            m_sel = (m_ptr + k) % NUM_VC;
                            break;
                        end
                    m_hold = 1'b1; m_age = 0; m_g = 1'b0;
                end
            end else if (tmo() || (sw_grant && flit_tail)) begin
                m_hold = 1'b0;
                m_ptr  = (m_sel + 1) % NUM_VC;
            end else if (sw_grant) begin
                m_g = 1'b1;
            end else if (!m_g && m_age < 15) begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_sel_valid", int'(sel_valid), int'(m_hold));
            chk("model_vc_deq", int'(vc_deq),
                (m_hold && sw_grant && !reset && !tmo()) ? (1 << m_sel) : 0);
            if (m_hold) chk("model_sel", int'(sel), m_sel);
        end
    end

    task automatic apply(input logic [NUM_VC-1:0] r, input logic g, input logic t, input logic rs);
        vc_req = r; sw_grant = g; flit_tail = t; reset = rs;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        apply('0, 1'b0, 1'b0, 1'b1); tick();
        chk("reset_sel", int'(sel), 0);
        chk("reset_valid", int'(sel_valid), 0);
        apply(5'b00100, 1'b0, 1'b0, 1'b0);
        chk("search_no_deq", int'(vc_deq), 0);
        tick();
        chk("first_sel", int'(sel), 2);
        chk("first_valid", int'(sel_valid), 1);
        apply('0, 1'b1, 1'b1, 1'b0);
        chk("tail_deq", int'(vc_deq), 5'b00100);
        tick();
        chk("bubble_valid", int'(sel_valid), 0);
        apply(5'b00011, 1'b0, 1'b0, 1'b0); tick();
        chk("wrap_sel", int'(sel), 0);
        apply('0, 1'b1, 1'b1, 1'b0); tick();
        apply(5'b11111, 1'b0, 1'b0, 1'b0); tick();
        chk("ptr1_sel", int'(sel), 1);
        for (int i = 0; i < 20; i++) begin
            apply('0, 1'b0, 1'b0, 1'b0); tick();
        end
        chk("age_hold_valid", int'(sel_valid), AGE_EN ? 0 : 1);
        if (!AGE_EN) chk("age_hold_sel", int'(sel), 1);
        apply('0, 1'b1, 1'b1, 1'b0); tick();
        apply(5'b10000, 1'b0, 1'b0, 1'b0); tick();
        chk("vc4_sel", int'(sel), 4);
        apply(5'b01111, 1'b1, 1'b0, 1'b0);
        chk("vc4_deq1", int'(vc_deq), 5'b10000);
        tick();
        chk("vc4_sel1", int'(sel), 4);
        apply(5'b00001, 1'b1, 1'b0, 1'b0);
        chk("vc4_deq2", int'(vc_deq), 5'b10000);
        tick();
        chk("vc4_sel2", int'(sel), 4);
        apply(5'b00110, 1'b1, 1'b1, 1'b0);
        chk("vc4_deq3", int'(vc_deq), 5'b10000);
        tick();
        chk("vc4_release", int'(sel_valid), 0);
        apply(5'b11111, 1'b0, 1'b0, 1'b0); tick();
        chk("ptr0_sel", int'(sel), 0);
        apply('0, 1'b1, 1'b1, 1'b0); tick();
        apply('0, 1'b1, 1'b1, 1'b0);
        chk("idle_grant_deq", int'(vc_deq), 0);
        tick();
        chk("idle_grant_valid", int'(sel_valid), 0);
        apply(5'b00100, 1'b0, 1'b0, 1'b0); tick();
        chk("after_idle_sel", int'(sel), 2);
        apply(5'b11111, 1'b1, 1'b1, 1'b1);
        chk("reset_hold_deq", int'(vc_deq), 0);
        tick();
        chk("reset_hold_sel", int'(sel), 0);
        chk("reset_hold_valid", int'(sel_valid), 0);
        apply(5'b11111, 1'b0, 1'b0, 1'b0); tick();
        chk("post_reset_sel", int'(sel), 0);
        apply('0, 1'b0, 1'b1, 1'b0); tick();
        chk("tail_only_valid", int'(sel_valid), 1);
        apply('0, 1'b1, 1'b0, 1'b0);
        chk("body_deq", int'(vc_deq), 5'b00001);
        tick();
        chk("body_valid", int'(sel_valid), 1);
        apply('0, 1'b1, 1'b1, 1'b0); tick();
        for (int i = 0; i < 300; i++) begin
            apply(NUM_VC'($urandom), 1'($urandom), ($urandom % 3) == 0, ($urandom % 50) == 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
